// File: rtl/encdec_pkg.sv
// Shared definitions for the 8-to-3 priority encoder / 3-to-8 decoder pair.
//   ENC_CODE_W / ENC_N_OUT : default code width and one-hot width
//   dec_state_t            : decoder FSM state encoding
//   onehot()               : code -> one-hot pattern, all-zero when code_valid=0
package encdec_pkg;

    localparam int ENC_CODE_W = 3;
    localparam int ENC_N_OUT  = 1 << ENC_CODE_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } dec_state_t;

    function automatic logic [ENC_N_OUT-1:0] onehot(input logic [ENC_CODE_W-1:0] code,
                                                    input logic                  code_valid);
        logic [ENC_N_OUT-1:0] v;
        v = '0;
        if (code_valid) v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_push     : write i_wr_data (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   o_rd_data  : head entry, valid whenever o_empty=0
//   o_count    : number of stored entries (0..2)
//   o_full     : o_count == 2
//   o_empty    : o_count == 0
module sync_fifo2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [1:0]       o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/priority_decoder_3to8_hold.sv
// Priority decoder with hold: accepts (code, code_valid) beats over a
// valid/ready handshake, buffers up to two of them, and drives each decoded
// one-hot pattern for HOLD consecutive cycles, back-to-back with no bubble.
//   clk, rst_n  : clock, synchronous active-low reset
//   code        : encoded index
//   code_valid  : 0 decodes to an all-zero pattern
//   s_valid     : upstream beat present
//   s_ready     : beat accepted on an edge where s_valid && s_ready
//   y           : decoded pattern (registered)
//   y_valid     : y carries a decoded beat (registered)
//   busy        : a beat is being driven or is buffered
//   dbg_state   : current FSM state
// Handshake: a beat transfers on every rising edge where s_valid && s_ready;
// s_ready depends only on reset and buffer occupancy, never on s_valid, and
// upstream must hold code/code_valid stable while s_valid=1 and s_ready=0.
module priority_decoder_3to8_hold
    import encdec_pkg::*;
#(
    parameter int CODE_W = ENC_CODE_W,
    parameter int N_OUT  = ENC_N_OUT,
    parameter int HOLD   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [N_OUT-1:0]  y,
    output logic              y_valid,
    output logic              busy,
    output dec_state_t        dbg_state
);

    localparam int                CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD - 1);

    if (N_OUT != (1 << CODE_W)) begin : g_bad_n_out
        $error("N_OUT must equal 2**CODE_W");
    end
    if (HOLD < 1) begin : g_bad_hold
        $error("HOLD must be at least 1");
    end

    dec_state_t        r_state;
    dec_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [N_OUT-1:0]  r_y;
    logic [N_OUT-1:0]  w_y_nxt;
    logic              r_y_valid;
    logic              w_y_valid_nxt;
    logic              w_pop;
    logic              w_load;
    logic              w_push;
    logic [CODE_W:0]   w_head;
    logic [1:0]        w_count;
    logic              w_full;
    logic              w_empty;

    assign s_ready = rst_n && !w_full;
    assign w_push  = s_valid && s_ready;

    sync_fifo2 #(
        .WIDTH (CODE_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wr_data ({code_valid, code}),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state. A pop always coincides with loading a new pattern; in DRIVE
    // it happens on the last hold cycle so consecutive beats abut.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == '0) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next output/counter values; the counter is reloaded before it can wrap.
    always_comb begin
        w_y_nxt       = r_y;
        w_y_valid_nxt = r_y_valid;
        w_cnt_nxt     = r_cnt;
        if (w_load) begin
            w_y_nxt       = onehot(w_head[CODE_W-1:0], w_head[CODE_W]);
            w_y_valid_nxt = 1'b1;
            w_cnt_nxt     = CNT_LOAD;
        end else if (r_state == ST_DRIVE) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end else begin
                w_y_nxt       = '0;
                w_y_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_y       <= w_y_nxt;
            r_y_valid <= w_y_valid_nxt;
        end
    end

    assign y         = r_y;
    assign y_valid   = r_y_valid;
    assign busy      = (r_state == ST_DRIVE) || (w_count != 2'd0);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_priority_decoder_3to8_hold.sv
module tb_priority_decoder_3to8_hold;
  import encdec_pkg::*;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT A (HOLD=4)
  logic [2:0] code;
  logic       code_valid, s_valid, s_ready, y_valid, busy;
  logic [7:0] y;
  dec_state_t dbg_state;

  // DUT B (HOLD=1)
  logic [2:0] code_b;
  logic       code_valid_b, s_valid_b, s_ready_b, y_valid_b, busy_b;
  logic [7:0] y_b;
  dec_state_t dbg_state_b;

  priority_decoder_3to8_hold #(.CODE_W(3), .N_OUT(8), .HOLD(HOLD_A)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
    .s_valid(s_valid), .s_ready(s_ready), .y(y), .y_valid(y_valid),
    .busy(busy), .dbg_state(dbg_state)
  );

  priority_decoder_3to8_hold #(.CODE_W(3), .N_OUT(8), .HOLD(HOLD_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .code(code_b), .code_valid(code_valid_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .y(y_b), .y_valid(y_valid_b),
    .busy(busy_b), .dbg_state(dbg_state_b)
  );

  // scoreboard state
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q_b[$];
  int vld_a = 0, rises_a = 0, vld_b = 0, rises_b = 0;

  // reference encoder: highest set bit wins
  function automatic void enc8to3(input logic [7:0] i, output logic [2:0] c, output logic v);
    c = 3'd0;
    v = 1'b0;
    for (int j = 0; j < 8; j++) if (i[j]) begin c = 3'(j); v = 1'b1; end
  endfunction

  // monitor: pops one expected pattern per y_valid cycle
  task automatic monitor();
    logic [7:0] e;
    logic prev_a = 1'b0, prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n_checks++;
        if (y_valid) begin
          vld_a++;
          if (!prev_a) rises_a++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL sb_a_unexpected: y=%h y_valid=1, expected nothing", y);
          end else begin
            e = exp_q.pop_front();
            if (y !== e) begin n_fail++; $display("FAIL sb_a_y: got %h expected %h", y, e); end
          end
        end else if (y !== 8'h00) begin
          n_fail++; $display("FAIL sb_a_idle_y: got %h expected 00", y);
        end
        n_checks++;
        if (y_valid_b) begin
          vld_b++;
          if (!prev_b) rises_b++;
          if (exp_q_b.size() == 0) begin
            n_fail++; $display("FAIL sb_b_unexpected: y=%h y_valid=1, expected nothing", y_b);
          end else begin
            e = exp_q_b.pop_front();
            if (y_b !== e) begin n_fail++; $display("FAIL sb_b_y: got %h expected %h", y_b, e); end
          end
        end else if (y_b !== 8'h00) begin
          n_fail++; $display("FAIL sb_b_idle_y: got %h expected 00", y_b);
        end
      end
      prev_a = y_valid;
      prev_b = y_valid_b;
    end
  endtask

  // driver: present one beat until accepted, then queue its expected pattern
  task automatic send(input bit to_b, input logic [2:0] c, input logic cv, input logic [7:0] expv);
    int guard = 0;
    logic ok;
    if (to_b) begin code_b = c; code_valid_b = cv; s_valid_b = 1'b1; end
    else      begin code = c;   code_valid = cv;   s_valid = 1'b1;   end
    forever begin
      ok = to_b ? s_ready_b : s_ready;
      @(posedge clk);
      if (ok) break;
      guard++;
      if (guard > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", guard);
        break;
      end
    end
    if (ok) begin
      if (to_b) for (int i = 0; i < HOLD_B; i++) exp_q_b.push_back(expv);
      else      for (int i = 0; i < HOLD_A; i++) exp_q.push_back(expv);
    end
    #1;
    if (to_b) s_valid_b = 1'b0;
    else      s_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit on_b);
    int guard = 0;
    while ((on_b ? (busy_b || y_valid_b) : (busy || y_valid)) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    n_checks++;
    if (on_b ? (busy_b || y_valid_b) : (busy || y_valid)) begin
      n_fail++; $display("FAIL drain_timeout: still busy after %0d cycles, required idle", guard);
    end
    n_checks++;
    if ((on_b ? exp_q_b.size() : exp_q.size()) != 0) begin
      n_fail++; $display("FAIL drain_leftover: %0d expected patterns never seen, required 0",
                         on_b ? exp_q_b.size() : exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; code = 3'd2; code_valid = 1'b1;
    s_valid_b = 1'b1; code_b = 3'd2; code_valid_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
    n_checks++; if (y !== 8'h00) begin n_fail++; $display("FAIL rst_y: got %h expected 00", y); end
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL rst_y_valid: got %b expected 0", y_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %b expected 0", dbg_state); end
    n_checks++; if (s_ready_b !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready_b: got %b expected 0", s_ready_b); end
    s_valid = 1'b0; s_valid_b = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rel_s_ready: got %b expected 1", s_ready); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rel_busy: got %b expected 0", busy); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL rel_busy_b: got %b expected 0", busy_b); end
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL rel_y_valid: got %b expected 0", y_valid); end
  endtask

  task automatic test_single();
    int v0 = vld_a;
    send(1'b0, 3'd3, 1'b1, 8'b0000_1000);
    n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL single_bypass: y_valid=%b at accept edge, expected 0", y_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_acc: got %b expected 1", busy); end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (y_valid !== 1'b1 || y !== 8'h08) begin
        n_fail++; $display("FAIL single_hold k+%0d: y=%h y_valid=%b expected 08/1", i, y, y_valid);
      end
      n_checks++; if (dbg_state !== ST_DRIVE) begin n_fail++; $display("FAIL single_state k+%0d: got %b expected 1", i, dbg_state); end
    end
    @(posedge clk); #1;
    n_checks++;
    if (y !== 8'h00 || y_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end: y=%h y_valid=%b busy=%b expected 00/0/0", y, y_valid, busy);
    end
    wait_idle(1'b0);
    n_checks++; if (vld_a - v0 != 4) begin n_fail++; $display("FAIL single_len: got %0d cycles expected 4", vld_a - v0); end
  endtask

  task automatic test_stream();
    int v0 = vld_a, r0 = rises_a;
    send(1'b0, 3'd0, 1'b1, 8'h01);
    send(1'b0, 3'd7, 1'b1, 8'h80);
    send(1'b0, 3'd5, 1'b1, 8'h20);
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL stream_full: s_ready=%b with 2 buffered, expected 0", s_ready); end
    wait_idle(1'b0);
    n_checks++; if (vld_a - v0 != 12) begin n_fail++; $display("FAIL stream_len: got %0d cycles expected 12", vld_a - v0); end
    n_checks++; if (rises_a - r0 != 1) begin n_fail++; $display("FAIL stream_gap: got %0d y_valid runs expected 1", rises_a - r0); end
  endtask

  task automatic test_invalid();
    int v0 = vld_a;
    send(1'b0, 3'd6, 1'b0, 8'h00);
    wait_idle(1'b0);
    n_checks++; if (vld_a - v0 != 4) begin n_fail++; $display("FAIL invalid_len: got %0d cycles expected 4", vld_a - v0); end
  endtask

  task automatic test_round_trip();
    logic [7:0] vec [3];
    logic [7:0] want [3];
    logic [2:0] c;
    logic v;
    int v0 = vld_a;
    vec[0] = 8'b0011_1110; want[0] = 8'b0010_0000;
    vec[1] = 8'b0000_0001; want[1] = 8'h01;
    vec[2] = 8'h00;        want[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      enc8to3(vec[i], c, v);
      send(1'b0, c, v, want[i]);
    end
    wait_idle(1'b0);
    n_checks++; if (vld_a - v0 != 12) begin n_fail++; $display("FAIL rt_len: got %0d cycles expected 12", vld_a - v0); end
  endtask

  task automatic test_reset_mid();
    int r0;
    send(1'b0, 3'd1, 1'b1, 8'h02);
    send(1'b0, 3'd2, 1'b1, 8'h04);
    send(1'b0, 3'd4, 1'b1, 8'h10);
    n_checks++; if (dbg_state !== ST_DRIVE || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre: state=%b s_ready=%b expected 1/0", dbg_state, s_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (y !== 8'h00 || y_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: y=%h y_valid=%b busy=%b expected 00/0/0", y, y_valid, busy);
    end
    exp_q.delete();
    exp_q_b.delete();
    rst_n = 1'b1;
    r0 = rises_a;
    repeat (12) @(posedge clk);
    #1;
    n_checks++; if (rises_a != r0) begin n_fail++; $display("FAIL mid_ghost: %0d discarded beats reappeared, expected 0", rises_a - r0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
  endtask

  task automatic test_hold1();
    int v0 = vld_b, r0 = rises_b;
    send(1'b1, 3'd0, 1'b1, 8'h01);
    send(1'b1, 3'd7, 1'b1, 8'h80);
    send(1'b1, 3'd5, 1'b1, 8'h20);
    wait_idle(1'b1);
    n_checks++; if (vld_b - v0 != 3) begin n_fail++; $display("FAIL hold1_len: got %0d cycles expected 3", vld_b - v0); end
    n_checks++; if (rises_b - r0 != 1) begin n_fail++; $display("FAIL hold1_gap: got %0d y_valid runs expected 1", rises_b - r0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; code = 3'd0; code_valid = 1'b0;
    s_valid_b = 1'b0; code_b = 3'd0; code_valid_b = 1'b0;
    fork
      monitor();
    join_none
    #1;
    test_reset();
    test_single();
    test_stream();
    test_invalid();
    test_round_trip();
    test_reset_mid();
    test_hold1();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
